axis_frame_fifo: RTL and testbench

//  Downstream stage of the 8-bit AXI-Stream register. Buffers the register's

---
 rtl/axis_frame_fifo.sv | 110 +++++++++++
 tb/tb_axis_frame_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : axis_frame_fifo
//  Brief   : 8-bit AXI-Stream byte FIFO with first-word fall-through output
//            and complete-frame counting. Define AXIS_FRAME_STORE_EN for
//            store-and-forward release; cut-through otherwise.
//  Revision: 1.0 - initial release
// ============================================================================
module axis_frame_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  level,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0]  c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_ONE_CNT   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] c_ONE_PTR   = ADDR_W'(1);

    // Each entry holds {last, data}; storage is deliberately not reset.
    logic [DATA_W:0]     r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]    r_level;
    logic [CNT_W-1:0]    r_frame_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_valid;
    logic                w_wr;
    logic                w_rd;
    logic                w_frame_in;
    logic                w_frame_out;
    logic [DATA_W:0]     w_head;

    assign w_full  = (r_level == c_DEPTH_CNT);
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];

`ifdef AXIS_FRAME_STORE_EN
    // Hold bytes until a whole frame is stored; a full FIFO releases anyway so
    // frames longer than the buffer cannot deadlock.
    assign w_valid = !w_empty && ((r_frame_cnt != '0) || w_full);
`else
    assign w_valid = !w_empty;
`endif

    assign w_wr        = s_valid && !w_full;
    assign w_rd        = w_valid && m_ready;
    assign w_frame_in  = w_wr && s_last;
    assign w_frame_out = w_rd && w_head[DATA_W];

    assign s_ready   = !w_full;
    assign m_valid   = w_valid;
    assign m_data    = w_valid ? w_head[DATA_W-1:0] : '0;
    assign m_last    = w_valid && w_head[DATA_W];
    assign level     = r_level;
    assign frame_cnt = r_frame_cnt;
    assign full      = w_full;
    assign empty     = w_empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_ONE_CNT;
                2'b01:   r_level <= r_level - c_ONE_CNT;
                default: r_level <= r_level;
            endcase
            case ({w_frame_in, w_frame_out})
                2'b10:   r_frame_cnt <= r_frame_cnt + c_ONE_CNT;
                2'b01:   r_frame_cnt <= r_frame_cnt - c_ONE_CNT;
                default: r_frame_cnt <= r_frame_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_axis_frame_fifo
//  Brief   : Directed bench for axis_frame_fifo with a queue-based model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_axis_frame_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              m_ready = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic [4:0]        level;
    logic [4:0]        frame_cnt;
    logic              full;
    logic              empty;

    int n_vec = 0;
    int n_err = 0;

    axis_frame_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .level(level), .frame_cnt(frame_cnt), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is simply an ordered queue of {last,data} bytes.
    logic [8:0] mq[$];

    function automatic int model_frames();
        int f = 0;
        foreach (mq[i]) if (mq[i][8]) f++;
        return f;
    endfunction

    function automatic bit model_valid();
        bit v;
        v = (mq.size() != 0);
`ifdef AXIS_FRAME_STORE_EN
        v = v && (model_frames() != 0 || mq.size() == DEPTH);
`endif
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin : p_model
        bit wr;
        bit rd;
        if (!reset) begin
            mq.delete();
        end else begin
            wr = s_valid && (mq.size() < DEPTH);
            rd = model_valid() && m_ready;
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back({s_last, s_data});
        end
    end

    always @(negedge clk) begin : p_compare
        check("m_valid",   32'(m_valid),   32'(model_valid()));
        check("s_ready",   32'(s_ready),   32'(mq.size() < DEPTH));
        check("level",     32'(level),     32'(mq.size()));
        check("frame_cnt", 32'(frame_cnt), 32'(model_frames()));
        check("full",      32'(full),      32'(mq.size() == DEPTH));
        check("empty",     32'(empty),     32'(mq.size() == 0));
        if (model_valid()) begin
            check("m_data", 32'(m_data), 32'(mq[0][7:0]));
            check("m_last", 32'(m_last), 32'(mq[0][8]));
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
        s_valid = v;
        s_data  = d;
        s_last  = l;
        m_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step(1'b1, 8'h99, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_level",   32'(level),   32'd0);
        check("rst_frames",  32'(frame_cnt), 32'd0);
        check("rst_empty",   32'(empty),   32'd1);
        check("rst_m_data",  32'(m_data),  32'd0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 0);

        // Three-byte frame held, then drained
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        check("t2_level",  32'(level),     32'd3);
        check("t2_frames", 32'(frame_cnt), 32'd1);
        check("t2_b0",     32'(m_data),    32'h12);
        check("t2_l0",     32'(m_last),    32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_b1",     32'(m_data),    32'h22);
        check("t2_l1",     32'(m_last),    32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_b2",     32'(m_data),    32'h33);
        check("t2_l2",     32'(m_last),    32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t2_level_end",  32'(level),     32'd0);
        check("t2_frames_end", 32'(frame_cnt), 32'd0);

        // Fill to full, overflow byte dropped, drain across pointer wrap
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("t3_full",    32'(full),    32'd1);
        check("t3_s_ready", 32'(s_ready), 32'd0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("t3_level",   32'(level),   32'd16);
        check("t3_first",   32'(m_data),  32'h01);
        repeat (17) step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h45, 1'b1, 1'b1);
        repeat (20) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_empty",   32'(empty),   32'd1);

        // Simultaneous write-with-last and read-with-last at level 5
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        step(1'b1, 8'hB3, 1'b0, 1'b0);
        step(1'b1, 8'hB4, 1'b1, 1'b0);
        check("t4_level",  32'(level),     32'd5);
        check("t4_frames", 32'(frame_cnt), 32'd2);
        check("t4_head",   32'(m_data),    32'hB0);
        check("t4_hlast",  32'(m_last),    32'd1);
        step(1'b1, 8'hB5, 1'b1, 1'b1);
        check("t4_level_both",  32'(level),     32'd5);
        check("t4_frames_both", 32'(frame_cnt), 32'd2);
        check("t4_head2",       32'(m_data),    32'hB1);
        repeat (8) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_empty",  32'(empty),     32'd1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("t5_level7", 32'(level), 32'd7);
        reset = 1'b0;
        #2;
        check("t5_async_level", 32'(level),   32'd0);
        check("t5_async_valid", 32'(m_valid), 32'd0);
        check("t5_async_empty", 32'(empty),   32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("t5_valid", 32'(m_valid), 32'd1);
        check("t5_data",  32'(m_data),  32'hAA);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_empty", 32'(empty),   32'd1);

        // Release policy: store-and-forward vs cut-through
        step(1'b1, 8'h55, 1'b0, 1'b0);
`ifdef AXIS_FRAME_STORE_EN
        check("t6_hold_55", 32'(m_valid), 32'd0);
`else
        check("t6_ct_valid", 32'(m_valid), 32'd1);
        check("t6_ct_data",  32'(m_data),  32'h55);
`endif
        step(1'b1, 8'h66, 1'b0, 1'b0);
`ifdef AXIS_FRAME_STORE_EN
        check("t6_hold_66", 32'(m_valid), 32'd0);
`endif
        step(1'b1, 8'h77, 1'b1, 1'b0);
        check("t6_valid",  32'(m_valid),   32'd1);
        check("t6_data",   32'(m_data),    32'h55);
        check("t6_level",  32'(level),     32'd3);
        check("t6_frames", 32'(frame_cnt), 32'd1);
        repeat (5) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_empty",  32'(empty),     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
